// File: rtl/pr_ren2sch_q.sv
// rtl/pr_ren2sch_q.sv - elastic rename-to-schedule queue with flush and tag-based selective squash
module pr_ren2sch_q #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 2,
   parameter int TAG_W  = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [DATA_W-1:0]            i_data,
   input  logic [TAG_W-1:0]             i_tag,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [DATA_W-1:0]            o_data,
   output logic [TAG_W-1:0]             o_tag,
   input  logic                         flush,
   input  logic                         squash_valid,
   input  logic [TAG_W-1:0]             squash_tag,
   input  logic [TAG_W-1:0]             rob_head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [TAG_W-1:0]  tag_q  [DEPTH];
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     keep;
   logic              push, pop, wr_en, younger_seen;
   logic [TAG_W-1:0]  branch_age, ent_age;
   logic [PW-1:0]     idx;

   // Handshake outputs depend only on registered occupancy.
   always_comb begin
      o_ready = (count_q < CW'(DEPTH));
      o_valid = (count_q != '0);
      push    = i_valid && o_ready;
      pop     = o_valid && i_ready;
   end

   assign o_data = data_q[head_q];
   assign o_tag  = tag_q[head_q];
   assign count  = count_q;

   // Ages are distances from the ROB head, so the compare survives tag wrap.
   always_comb begin
      keep         = '0;
      younger_seen = 1'b0;
      idx          = '0;
      ent_age      = '0;
      branch_age   = squash_tag - rob_head;
      for (int i = 0; i < DEPTH; i++) begin
         idx     = head_q + PW'(i);
         ent_age = tag_q[idx] - rob_head;
         if ((CW'(i) < count_q) && !younger_seen) begin
            if (ent_age > branch_age) begin
               younger_seen = 1'b1;
            end else begin
               keep = keep + CW'(1);
            end
         end
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      wr_en   = 1'b0;
      if (flush) begin
         tail_d  = head_q;
         count_d = '0;
      end else if (squash_valid) begin
         // Squashed entries form a suffix; the same-cycle push is always younger.
         tail_d = head_q + PW'(keep);
         if (pop && (keep != '0)) begin
            head_d  = head_q + PW'(1);
            count_d = keep - CW'(1);
         end else begin
            count_d = keep;
         end
      end else begin
         wr_en = push;
         if (push) begin
            tail_d = tail_q + PW'(1);
         end
         if (pop) begin
            head_d = head_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (wr_en) begin
            data_q[tail_q] <= i_data;
            tag_q[tail_q]  <= i_tag;
         end
      end
   end

endmodule
